// File: rtl/uart2ps2_pkg.sv
// rtl/uart2ps2_pkg.sv - shared types and header field constants for the uart2ps2 dispatcher
// Optional feature macro: UART2PS2_CHECKSUM_EN (adds the CHECK state).
package uart2ps2_pkg;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_PAYLOAD,
    ST_DROP
`ifdef UART2PS2_CHECKSUM_EN
    , ST_CHECK
`endif
  } state_t;

  localparam logic [3:0] SYNC_NIBBLE = 4'hA;
  localparam logic       CHAN_KBD    = 1'b0;
  localparam logic       CHAN_MOUSE  = 1'b1;

  localparam int HDR_SYNC_MSB = 7;
  localparam int HDR_SYNC_LSB = 4;
  localparam int HDR_CHAN_BIT = 3;
  localparam int HDR_LEN_MSB  = 2;
  localparam int HDR_LEN_LSB  = 0;

endpackage

// File: rtl/ps2_byte_fifo.sv
// rtl/ps2_byte_fifo.sv - first-word fall-through byte FIFO with write/commit/rollback pointers
// Readers only see bytes up to the committed pointer; free space counts uncommitted bytes as used.
module ps2_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     commit,
  input  logic                     rollback,
  output logic [$clog2(DEPTH):0]   free,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] cmt_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] used;
  logic [AW:0] committed;
  logic        pop;

  assign used      = wr_ptr - rd_ptr;
  assign committed = cmt_ptr - rd_ptr;
  assign free      = DEPTH_W - used;
  assign rd_valid  = committed != '0;
  assign rd_data   = rd_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign pop       = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Commit includes a write issued in the same cycle so the no-checksum build commits as it writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      cmt_ptr <= '0;
      rd_ptr  <= '0;
    end else begin
      if (rollback)   wr_ptr <= cmt_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (commit)     cmt_ptr <= wr_en ? wr_ptr + 1'b1 : wr_ptr;
      if (pop)        rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_ps2_dispatch.sv
// rtl/uart_ps2_dispatch.sv - parses framed UART packets and routes payload bytes to keyboard/mouse FIFOs
// Optional feature macro: UART2PS2_CHECKSUM_EN (trailing XOR checksum, commit/rollback per packet).
module uart_ps2_dispatch
  import uart2ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_finish,
  input  logic [7:0] rx_data,
  output logic [7:0] kbd_data,
  output logic       kbd_valid,
  input  logic       kbd_ready,
  output logic [7:0] mouse_data,
  output logic       mouse_valid,
  input  logic       mouse_ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES);

  logic       rx_prev;
  logic       byte_evt;
  logic [7:0] byte_q;

  // rx_prev resets high so a level already present at reset release is not a new byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_prev  <= 1'b1;
      byte_evt <= 1'b0;
      byte_q   <= '0;
    end else begin
      rx_prev  <= rx_finish;
      byte_evt <= rx_finish & ~rx_prev;
      byte_q   <= rx_data;
    end
  end

  state_t        state, state_nxt;
  logic          chan, chan_nxt;
  logic [3:0]    remain, remain_nxt;
  logic [TW-1:0] idle_cnt;
  logic          idle_hit;
  logic          timeout;
  logic          wr_en;
  logic [AW:0]   kbd_free, mouse_free, sel_free;
  logic [3:0]    hdr_sync;
  logic          hdr_chan;
  logic [2:0]    hdr_len;
  logic          fits;
  logic          kbd_wr, mouse_wr;

`ifdef UART2PS2_CHECKSUM_EN
  logic [7:0] csum, csum_nxt;
  logic       commit_p;
  logic       rollback_p;
`endif

  assign hdr_sync = byte_q[HDR_SYNC_MSB:HDR_SYNC_LSB];
  assign hdr_chan = byte_q[HDR_CHAN_BIT];
  assign hdr_len  = byte_q[HDR_LEN_MSB:HDR_LEN_LSB];
  assign sel_free = (hdr_chan == CHAN_MOUSE) ? mouse_free : kbd_free;
  assign fits     = sel_free >= (AW+1)'(hdr_len);
  assign idle_hit = idle_cnt == IDLE_LIMIT;
  assign timeout  = (state != ST_HDR) && idle_hit && !byte_evt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_HDR;
      chan     <= CHAN_KBD;
      remain   <= '0;
      idle_cnt <= '0;
`ifdef UART2PS2_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      state  <= state_nxt;
      chan   <= chan_nxt;
      remain <= remain_nxt;
`ifdef UART2PS2_CHECKSUM_EN
      csum   <= csum_nxt;
`endif
      if (state == ST_HDR || byte_evt) idle_cnt <= '0;
      else if (!idle_hit)              idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    chan_nxt   = chan;
    remain_nxt = remain;
    wr_en      = 1'b0;
    frame_err  = 1'b0;
    overflow   = 1'b0;
`ifdef UART2PS2_CHECKSUM_EN
    csum_nxt   = csum;
    commit_p   = 1'b0;
    rollback_p = 1'b0;
`endif
    case (state)
      ST_HDR: begin
        if (byte_evt) begin
          if (hdr_sync != SYNC_NIBBLE || hdr_len == 3'd0) begin
            frame_err = 1'b1;
          end else if (fits) begin
            chan_nxt   = hdr_chan;
            remain_nxt = {1'b0, hdr_len};
            state_nxt  = ST_PAYLOAD;
`ifdef UART2PS2_CHECKSUM_EN
            csum_nxt   = byte_q;
`endif
          end else begin
            overflow   = 1'b1;
            state_nxt  = ST_DROP;
`ifdef UART2PS2_CHECKSUM_EN
            // the trailing checksum byte belongs to the dropped packet too
            remain_nxt = {1'b0, hdr_len} + 4'd1;
`else
            remain_nxt = {1'b0, hdr_len};
`endif
          end
        end
      end
      ST_PAYLOAD: begin
        if (timeout) begin
          frame_err  = 1'b1;
          state_nxt  = ST_HDR;
`ifdef UART2PS2_CHECKSUM_EN
          rollback_p = 1'b1;
`endif
        end else if (byte_evt) begin
          wr_en      = 1'b1;
          remain_nxt = remain - 4'd1;
`ifdef UART2PS2_CHECKSUM_EN
          csum_nxt   = csum ^ byte_q;
          if (remain == 4'd1) state_nxt = ST_CHECK;
`else
          if (remain == 4'd1) state_nxt = ST_HDR;
`endif
        end
      end
      ST_DROP: begin
        if (timeout) begin
          frame_err = 1'b1;
          state_nxt = ST_HDR;
        end else if (byte_evt) begin
          remain_nxt = remain - 4'd1;
          if (remain == 4'd1) state_nxt = ST_HDR;
        end
      end
`ifdef UART2PS2_CHECKSUM_EN
      ST_CHECK: begin
        if (timeout) begin
          frame_err  = 1'b1;
          rollback_p = 1'b1;
          state_nxt  = ST_HDR;
        end else if (byte_evt) begin
          if (byte_q == csum) begin
            commit_p = 1'b1;
          end else begin
            rollback_p = 1'b1;
            frame_err  = 1'b1;
          end
          state_nxt = ST_HDR;
        end
      end
`endif
      default: state_nxt = ST_HDR;
    endcase
  end

  assign kbd_wr   = wr_en && (chan == CHAN_KBD);
  assign mouse_wr = wr_en && (chan == CHAN_MOUSE);

  ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_kbd_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (kbd_wr),
    .wr_data  (byte_q),
`ifdef UART2PS2_CHECKSUM_EN
    .commit   (commit_p && (chan == CHAN_KBD)),
    .rollback (rollback_p && (chan == CHAN_KBD)),
`else
    .commit   (kbd_wr),
    .rollback (1'b0),
`endif
    .free     (kbd_free),
    .rd_data  (kbd_data),
    .rd_valid (kbd_valid),
    .rd_ready (kbd_ready)
  );

  ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_mouse_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (mouse_wr),
    .wr_data  (byte_q),
`ifdef UART2PS2_CHECKSUM_EN
    .commit   (commit_p && (chan == CHAN_MOUSE)),
    .rollback (rollback_p && (chan == CHAN_MOUSE)),
`else
    .commit   (mouse_wr),
    .rollback (1'b0),
`endif
    .free     (mouse_free),
    .rd_data  (mouse_data),
    .rd_valid (mouse_valid),
    .rd_ready (mouse_ready)
  );

endmodule

// File: doc/uart_ps2_dispatch.md
# uart_ps2_dispatch

Packet dispatcher between the UART receiver and the two PS/2 device-side transmitters of the uart2ps2 bridge. Consumes completed bytes from the UART receiver and parses a framed host protocol (header plus 1–7 payload bytes). Routes each payload to a per-channel byte FIFO for the keyboard or the mouse. Each FIFO is drained by its PS/2 transmitter through a valid/ready handshake.

## Interface
- `FIFO_DEPTH`, default 8: bytes per channel FIFO; power of two, ≥8.
- `TIMEOUT_CYCLES`, default 500000: inter-byte idle limit inside a packet (10 ms at 50 MHz).
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_finish`  in  1  UART byte-done level; held high for about one bit period per byte.
- `rx_data`  in  8  UART byte; stable while `rx_finish` is high.
- `kbd_data`  out  8  keyboard FIFO head byte.
- `kbd_valid`  out  1  keyboard FIFO head byte is valid.
- `kbd_ready`  in  1  keyboard transmitter accepts the head byte.
- `mouse_data`  out  8  mouse FIFO head byte.
- `mouse_valid`  out  1  mouse FIFO head byte is valid.
- `mouse_ready`  in  1  mouse transmitter accepts the head byte.
- `frame_err`  out  1  one-cycle pulse: bad header, timeout or bad checksum.
- `overflow`  out  1  one-cycle pulse: packet dropped for lack of FIFO space.

## Operation
- **Byte strobe.** A byte event is a rising edge of `rx_finish`, taken against a registered copy of the previous value.
  - The previous-value register resets to 1, so releasing reset while `rx_finish` is high produces no event.
- **Header format.**
  - [7:4] must equal 4'hA.
  - [3] selects the channel: 0 = keyboard, 1 = mouse.
  - [2:0] is the payload length LEN, range 1–7.
- **FSM states:** HDR, PAYLOAD, DROP, CHECK (CHECK exists only with the checksum option).
- **HDR**
  - Sync nibble ≠ A, or LEN = 0: pulse `frame_err`, stay in HDR.
  - Free space ≥ LEN: latch channel and LEN, then go to PAYLOAD.
    - Free space is FIFO_DEPTH minus occupancy, and occupancy includes uncommitted bytes.
  - Free space < LEN: pulse `overflow` and go to DROP.
- **PAYLOAD.** Each byte is written to the selected FIFO and the remaining count decrements.
  - After the last byte: go to CHECK if the checksum option is enabled, otherwise to HDR.
  - The admission check guarantees no write is ever issued to a full FIFO.
- **DROP.** Discards LEN bytes, then returns to HDR.
- **Timeout.** In PAYLOAD, DROP or CHECK, an idle counter runs and clears on every byte event.
  - Reaching TIMEOUT_CYCLES pulses `frame_err` and returns to HDR.
  - Bytes already written follow the commit rules under Configuration.
- **FIFOs.** First-word fall-through.
  - `valid` is high when the committed count is nonzero.
  - A pop happens when `valid && ready`.
  - A pop and a write in the same cycle are both performed.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- **Reset values.** All outputs are 0. Both FIFOs are empty, the FSM is in HDR, and the counters are 0. Reset asserted mid-packet discards everything immediately.

## Timing
- Edge seen in cycle N → FSM acts and the FIFO is written in N+1 → `*_valid`/`*_data` visible in N+2. This is the path when each byte is committed as it is written.
- `frame_err` and `overflow` pulse in N+1 relative to the causing edge. A timeout error pulses in the cycle the counter reaches its limit.
- After a pop, the next head byte is presented in the following cycle; the FIFO sustains one byte per cycle.
- The idle counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates.

## Configuration
- **`UART2PS2_CHECKSUM_EN` defined**
  - Each packet carries a trailing byte equal to the XOR of the header and all payload bytes.
  - Payload writes advance only the FIFO's write pointer; readers see only the committed pointer.
  - In CHECK: a match commits (committed pointer ← write pointer); a mismatch or timeout rolls back (write pointer ← committed pointer) and pulses `frame_err`.
  - Latency to `valid` is counted from the checksum byte edge: N+2.
- **Not defined**
  - No checksum byte; every write commits immediately.
  - On timeout, already-written bytes remain and are delivered.

## Structure
- **Package `uart2ps2_pkg`:** FSM state enum, `SYNC_NIBBLE` = 4'hA, `CHAN_KBD`/`CHAN_MOUSE`, header field bit positions.
- **Sub-module `ps2_byte_fifo`:** FIFO with write/commit/rollback and valid/ready read port; instantiated twice.
  - Without `UART2PS2_CHECKSUM_EN`, commit is tied high on every write.

## Test plan
- Send 0xA2, 0x1C, 0xF0 with `kbd_ready`=1 → `kbd_data` 0x1C then 0xF0, each with `kbd_valid`; `mouse_valid` stays 0.
- Send 0xAB, 0x08, 0x01, 0xFF with `mouse_ready`=0 → `mouse_valid`=1 holding 0x08; release ready → 0x08, 0x01, 0xFF on consecutive cycles.
- Send 0x55, then 0xA1, 0x5A → one `frame_err` pulse; 0x5A delivered on the keyboard channel.
- With `kbd_ready`=0 and FIFO_DEPTH=8, send 0xA7 + 7 bytes, then 0xA2 + 2 bytes → one `overflow` pulse; exactly 7 bytes drain after ready rises.
- Send 0xA3 and 0x11, then idle for TIMEOUT_CYCLES → `frame_err` and FSM back in HDR; then 0xA1, 0x22 → 0x22 delivered.
- Checksum option enabled:
  - Send 0xA1, 0x1C, 0xBD → 0x1C delivered.
  - Send 0xA1, 0x1C, 0x00 → `frame_err`; `kbd_valid` never rises.
  - With `rx_finish`=1 during reset release → no byte event.
